serial_operand_driver: RTL and testbench
========================================

// Module: serial_operand_driver
// PURPOSE
// Initiator side of the LSB-first serial-add interface. Accepts parallel operands
// through a start/ready handshake, pulses the adder's clear, then shifts operand
// bits out one per clock. Waits for the adder's valid, captures the parallel sum
// and carry, and reports completion with a one-cycle done pulse, or an error on timeout.
// PARAMETERS
// WIDTH      4  operand and result width in bits; also the number of shift cycles
// CLR_CYCLES 1  cycles add_rst is held high before the first bit (>=1)
// TIMEOUT    8  maximum WAIT cycles for sum_valid_in before err is raised (>=1)
// PORTS
// clk          in   1      rising-edge clock, single domain
// rst          in   1      asynchronous, active-low reset
// start        in   1      request; accepted only on a clock edge where ready=1
// op_a         in   WIDTH  operand A, latched on start accept
// op_b         in   WIDTH  operand B, latched on start accept
// op_cin       in   1      carry-in, latched on start accept
// ready        out  1      1 only in IDLE
// add_rst      out  1      active-high synchronous clear to the serial adder
// a            out  1      serial bit of A, LSB first
// b            out  1      serial bit of B, LSB first
// carryin      out  1      latched op_cin, driven from CLEAR through WAIT
// bit_idx      out  CW     index of the bit on a/b; CW = $clog2(WIDTH) (min 1)
// sum_in       in   WIDTH  adder parallel sum (y)
// cout_in      in   1      adder carry-out
// sum_valid_in in   1      adder result-valid level
// result       out  WIDTH  captured sum; held until the next start accept
// result_cout  out  1      captured carry; held as for result
// done         out  1      one-cycle pulse in the DONE state
// err          out  1      timeout flag; set at DONE, cleared on the next start accept
// BEHAVIOUR
// - All outputs are registered. While rst=0: state=IDLE, ready=1, and all other outputs are 0.
// - FSM: IDLE -(start)-> CLEAR -(CLR_CYCLES done)-> SHIFT -(WIDTH bits done)-> WAIT
//   -(sum_valid_in | timeout)-> DONE -> IDLE.
// - Timing from the accept edge (cycle 0): CLEAR occupies cycles 1..CLR_CYCLES with add_rst=1.
//   SHIFT cycle k (k=0..WIDTH-1) drives a=A[k], b=B[k], bit_idx=k, add_rst=0.
//   The adder samples each bit at the end of its cycle.
// - WAIT: a=b=0 and bit_idx holds WIDTH-1. sum_valid_in is sampled every edge.
//   - When sum_valid_in=1: result<=sum_in, result_cout<=cout_in, err<=0, go to DONE.
//   - After TIMEOUT WAIT cycles with no valid: result<=0, result_cout<=0, err<=1, go to DONE.
// - Nominal latency with defaults and valid in the first WAIT cycle: done=1 in cycle 7.
// - DONE: done=1 for exactly 1 cycle and ready=0, so a start in DONE is ignored.
//   IDLE follows, and ready=1 in the next cycle.
// - start with ready=0 is ignored and never queued; the latched operands do not change.
// - Operand inputs are don't-care except on the accept edge.
// - In IDLE: a=b=carryin=0, add_rst=0, bit_idx=0.
// - Asynchronous reset mid-operation forces IDLE immediately. The adder is not cleared by this block;
//   the next operation's CLEAR state clears it.
// - Counters are sized so CLR_CYCLES, WIDTH and TIMEOUT never wrap.
// TESTING (bench includes a behavioural LSB-first serial adder model on a/b/carryin/add_rst)
// 1 rst=0 asserted during SHIFT -> same delta: ready=1; a=b=carryin=add_rst=done=err=0; bit_idx=0
// 2 op_a=5, op_b=5, op_cin=0 -> a stream 1,0,1,0 and b stream 1,0,1,0; done in cycle 7;
//   result=10, result_cout=0
// 3 op_a=10, op_b=5 -> result=15, cout=0; then op_a=6, op_b=10 -> result=0, result_cout=1, err=0
// 4 start with op_a=3 while busy in the 5+5 operation -> ignored; result=10; start during DONE also ignored
// 5 model holds sum_valid_in=0 -> done 8 WAIT cycles after SHIFT ends; err=1, result=0;
//   the next start clears err
// 6 CLR_CYCLES=3, WIDTH=8, op_a=200, op_b=100, op_cin=1 -> add_rst high exactly 3 cycles;
//   result=45, result_cout=1

Source files
------------

// File: rtl/serial_operand_driver_if.sv
// Operand request, serial-adder and result signals
// of the serial operand driver.
interface serial_operand_driver_if #(
  parameter int WIDTH = 4,
  parameter int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) ();
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             ready;
  logic             add_rst;
  logic             a;
  logic             b;
  logic             carryin;
  logic [CW-1:0]    bit_idx;
  logic [WIDTH-1:0] sum_in;
  logic             cout_in;
  logic             sum_valid_in;
  logic [WIDTH-1:0] result;
  logic             result_cout;
  logic             done;
  logic             err;

  modport master (
    input  start, op_a, op_b, op_cin,
    input  sum_in, cout_in, sum_valid_in,
    output ready, add_rst, a, b, carryin,
    output bit_idx, result, result_cout,
    output done, err
  );

  modport slave (
    output start, op_a, op_b, op_cin,
    output sum_in, cout_in, sum_valid_in,
    input  ready, add_rst, a, b, carryin,
    input  bit_idx, result, result_cout,
    input  done, err
  );
endinterface

// File: rtl/serial_operand_driver.sv
// Drives LSB-first operands into a serial adder
// and captures its parallel sum / carry.
module serial_operand_driver #(
  parameter int WIDTH      = 4,
  parameter int CLR_CYCLES = 1,
  parameter int TIMEOUT    = 8
) (
  input logic clk,
  input logic rst,
  serial_operand_driver_if.master bus
);
  localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int M1   = (CLR_CYCLES > WIDTH) ? CLR_CYCLES : WIDTH;
  localparam int CMAX = (M1 > TIMEOUT) ? M1 : TIMEOUT;
  localparam int CNTW = $clog2(CMAX + 1);

  localparam logic [CNTW-1:0] CLR_LAST = CNTW'(CLR_CYCLES - 1);
  localparam logic [CNTW-1:0] BIT_LAST = CNTW'(WIDTH - 1);
  localparam logic [CNTW-1:0] TO_LAST  = CNTW'(TIMEOUT - 1);
  localparam logic [CW-1:0]   IDX_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SHIFT, S_WAIT, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic             cin_q, cin_d;
  logic             ready_q, ready_d;
  logic             arst_q, arst_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             cy_q, cy_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             rco_q, rco_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // Next state and next registered output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    cin_d   = cin_q;
    res_d   = res_q;
    rco_d   = rco_q;
    err_d   = err_q;
    ready_d = 1'b0;
    arst_d  = 1'b0;
    a_d     = 1'b0;
    b_d     = 1'b0;
    cy_d    = 1'b0;
    idx_d   = '0;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (bus.start) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          sha_d   = bus.op_a;
          shb_d   = bus.op_b;
          cin_d   = bus.op_cin;
          err_d   = 1'b0;
          ready_d = 1'b0;
          arst_d  = 1'b1;
          cy_d    = bus.op_cin;
        end
      end
      S_CLEAR: begin
        cy_d = cin_q;
        if (cnt_q == CLR_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          a_d     = sha_q[0];
          b_d     = shb_q[0];
          sha_d   = sha_q >> 1;
          shb_d   = shb_q >> 1;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          arst_d = 1'b1;
        end
      end
      S_SHIFT: begin
        cy_d = cin_q;
        if (cnt_q == BIT_LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
          idx_d   = IDX_LAST;
        end else begin
          cnt_d = cnt_q + 1'b1;
          idx_d = idx_q + 1'b1;
          a_d   = sha_q[0];
          b_d   = shb_q[0];
          sha_d = sha_q >> 1;
          shb_d = shb_q >> 1;
        end
      end
      S_WAIT: begin
        cy_d  = cin_q;
        idx_d = IDX_LAST;
        if (bus.sum_valid_in) begin
          state_d = S_DONE;
          res_d   = bus.sum_in;
          rco_d   = bus.cout_in;
          err_d   = 1'b0;
          done_d  = 1'b1;
          cy_d    = 1'b0;
          idx_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_DONE;
          res_d   = '0;
          rco_d   = 1'b0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          cy_d    = 1'b0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, operand latches and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sha_q   <= '0;
      shb_q   <= '0;
      cin_q   <= 1'b0;
      ready_q <= 1'b1;
      arst_q  <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      cy_q    <= 1'b0;
      idx_q   <= '0;
      res_q   <= '0;
      rco_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      cin_q   <= cin_d;
      ready_q <= ready_d;
      arst_q  <= arst_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cy_q    <= cy_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      rco_q   <= rco_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.ready       = ready_q;
  assign bus.add_rst     = arst_q;
  assign bus.a           = a_q;
  assign bus.b           = b_q;
  assign bus.carryin     = cy_q;
  assign bus.bit_idx     = idx_q;
  assign bus.result      = res_q;
  assign bus.result_cout = rco_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_serial_operand_driver.sv
// Directed bench for serial_operand_driver with
// behavioural serial adders and a result scoreboard.
module tb_serial_operand_driver;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_operand_driver_if #(.WIDTH(4)) if0 ();
  serial_operand_driver_if #(.WIDTH(8)) if1 ();

  serial_operand_driver #(
    .WIDTH(4), .CLR_CYCLES(1), .TIMEOUT(8)
  ) u0 (.clk(clk), .rst(rst), .bus(if0.master));

  serial_operand_driver #(
    .WIDTH(8), .CLR_CYCLES(3), .TIMEOUT(8)
  ) u1 (.clk(clk), .rst(rst), .bus(if1.master));

  typedef struct {
    int res;
    int cout;
    int err;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit hold0 = 1'b0;

  task automatic chk(string tag, int obs, int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // serial adder model for the 4-bit instance
  logic [3:0] m0_sum;
  logic       m0_c, m0_arm, m0_v;
  int         m0_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m0_sum <= '0; m0_c <= 1'b0; m0_arm <= 1'b0;
      m0_v <= 1'b0; m0_cnt <= 0;
    end else if (if0.add_rst) begin
      m0_sum <= '0; m0_c <= if0.carryin; m0_arm <= 1'b1;
      m0_v <= 1'b0; m0_cnt <= 0;
    end else if (m0_arm && m0_cnt < 4) begin
      m0_sum[m0_cnt] <= if0.a ^ if0.b ^ m0_c;
      m0_c <= (if0.a & if0.b) | (if0.a & m0_c) | (if0.b & m0_c);
      m0_cnt <= m0_cnt + 1;
      if (m0_cnt == 3) begin
        m0_v <= !hold0;
        m0_arm <= 1'b0;
      end
    end
  end
  assign if0.sum_in = m0_sum;
  assign if0.cout_in = m0_c;
  assign if0.sum_valid_in = m0_v;

  // serial adder model for the 8-bit instance
  logic [7:0] m1_sum;
  logic       m1_c, m1_arm, m1_v;
  int         m1_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m1_sum <= '0; m1_c <= 1'b0; m1_arm <= 1'b0;
      m1_v <= 1'b0; m1_cnt <= 0;
    end else if (if1.add_rst) begin
      m1_sum <= '0; m1_c <= if1.carryin; m1_arm <= 1'b1;
      m1_v <= 1'b0; m1_cnt <= 0;
    end else if (m1_arm && m1_cnt < 8) begin
      m1_sum[m1_cnt] <= if1.a ^ if1.b ^ m1_c;
      m1_c <= (if1.a & if1.b) | (if1.a & m1_c) | (if1.b & m1_c);
      m1_cnt <= m1_cnt + 1;
      if (m1_cnt == 7) begin
        m1_v <= 1'b1;
        m1_arm <= 1'b0;
      end
    end
  end
  assign if1.sum_in = m1_sum;
  assign if1.cout_in = m1_c;
  assign if1.sum_valid_in = m1_v;

  task automatic pop_cmp(string tag, int res, int cout, int err);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_result"}, res, e.res);
    chk({tag, "_cout"}, cout, e.cout);
    chk({tag, "_err"}, err, e.err);
  endtask

  task automatic run0(string tag, int va, int vb, int vc, bit hold);
    exp_t e;
    int cyc;
    int s;
    s = va + vb + vc;
    e.res = hold ? 0 : (s % 16);
    e.cout = hold ? 0 : (s / 16);
    e.err = hold ? 1 : 0;
    @(negedge clk);
    if0.start = 1'b1;
    if0.op_a = 4'(va);
    if0.op_b = 4'(vb);
    if0.op_cin = 1'(vc);
    sb.push_back(e);
    @(negedge clk);
    if0.start = 1'b0;
    chk({tag, "_err_clr"}, int'(if0.err), 0);
    cyc = 1;
    while (!if0.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, cyc, hold ? 14 : 7);
    pop_cmp(tag, int'(if0.result), int'(if0.result_cout),
            int'(if0.err));
  endtask

  initial begin
    logic [3:0] s5;
    exp_t e;
    int cyc;
    int nclr;
    s5 = 4'd5;
    if0.start = 1'b0; if0.op_a = '0; if0.op_b = '0; if0.op_cin = 1'b0;
    if1.start = 1'b0; if1.op_a = '0; if1.op_b = '0; if1.op_cin = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_ready", int'(if0.ready), 1);
    chk("rst_done", int'(if0.done), 0);
    chk("rst_result", int'(if0.result), 0);
    chk("rst_add_rst", int'(if0.add_rst), 0);
    rst = 1'b1;

    // 5 + 5 with stream checks, busy start and DONE start
    @(negedge clk);
    if0.start = 1'b1;
    if0.op_a = 4'd5; if0.op_b = 4'd5; if0.op_cin = 1'b0;
    e.res = 10; e.cout = 0; e.err = 0;
    sb.push_back(e);
    @(negedge clk);
    if0.start = 1'b0;
    chk("c1_add_rst", int'(if0.add_rst), 1);
    chk("c1_ready", int'(if0.ready), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if0.start = 1'b1;
        if0.op_a = 4'd3; if0.op_b = 4'd3;
      end else begin
        if0.start = 1'b0;
      end
      chk($sformatf("sh%0d_a", k), int'(if0.a), int'(s5[k]));
      chk($sformatf("sh%0d_b", k), int'(if0.b), int'(s5[k]));
      chk($sformatf("sh%0d_idx", k), int'(if0.bit_idx), k);
      chk($sformatf("sh%0d_add_rst", k), int'(if0.add_rst), 0);
    end
    @(negedge clk);
    chk("c6_done", int'(if0.done), 0);
    chk("c6_idx", int'(if0.bit_idx), 3);
    chk("c6_a", int'(if0.a), 0);
    @(negedge clk);
    chk("c7_done", int'(if0.done), 1);
    chk("c7_ready", int'(if0.ready), 0);
    pop_cmp("t2", int'(if0.result), int'(if0.result_cout),
            int'(if0.err));
    if0.start = 1'b1;
    if0.op_a = 4'd3; if0.op_b = 4'd3;
    @(negedge clk);
    if0.start = 1'b0;
    chk("c8_done", int'(if0.done), 0);
    chk("c8_ready", int'(if0.ready), 1);
    @(negedge clk);
    chk("c9_ready", int'(if0.ready), 1);
    chk("c9_result", int'(if0.result), 10);

    run0("t3a", 10, 5, 0, 1'b0);
    run0("t3b", 6, 10, 0, 1'b0);
    run0("cin", 7, 8, 1, 1'b0);

    hold0 = 1'b1;
    run0("t5to", 3, 4, 0, 1'b1);
    hold0 = 1'b0;
    run0("t5nx", 1, 2, 0, 1'b0);

    // reset in the middle of SHIFT
    @(negedge clk);
    if0.start = 1'b1;
    if0.op_a = 4'hF; if0.op_b = 4'hF; if0.op_cin = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_shift", int'(if0.a), 1);
    rst = 1'b0;
    #1;
    chk("mr_ready", int'(if0.ready), 1);
    chk("mr_a", int'(if0.a), 0);
    chk("mr_b", int'(if0.b), 0);
    chk("mr_carryin", int'(if0.carryin), 0);
    chk("mr_add_rst", int'(if0.add_rst), 0);
    chk("mr_done", int'(if0.done), 0);
    chk("mr_err", int'(if0.err), 0);
    chk("mr_idx", int'(if0.bit_idx), 0);
    @(negedge clk);
    rst = 1'b1;

    // 8-bit, three clear cycles, carry in
    @(negedge clk);
    if1.start = 1'b1;
    if1.op_a = 8'd200; if1.op_b = 8'd100; if1.op_cin = 1'b1;
    e.res = 45; e.cout = 1; e.err = 0;
    sb.push_back(e);
    @(negedge clk);
    if1.start = 1'b0;
    cyc = 1;
    nclr = 0;
    while (!if1.done && cyc < 60) begin
      if (if1.add_rst) nclr++;
      @(negedge clk);
      cyc++;
    end
    chk("t6_clr_cycles", nclr, 3);
    chk("t6_latency", cyc, 13);
    pop_cmp("t6", int'(if1.result), int'(if1.result_cout),
            int'(if1.err));

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
